// File: rtl/sign_zero_extend.sv
// ---------------------------------------------------------------------------
// sign_zero_extend
//   Immediate-field extender for the single-cycle CPU datapath. Widens the
//   instruction immediate from IN_WIDTH to OUT_WIDTH bits. It either
//   sign-extends the value (arithmetic, load/store and branch offsets) or
//   zero-extends it (logical immediates). The result is registered once, so
//   Out is a clean flop output for the ALU B-operand mux and the branch adder.
//
// Parameters
//   IN_WIDTH   width of Immediate (1 .. OUT_WIDTH)
//   OUT_WIDTH  width of Out
//
// Ports
//   CLK        in   1          system clock, rising-edge active
//   Reset      in   1          synchronous, active-high; forces Out to 0
//   Immediate  in   IN_WIDTH   raw immediate field
//   ExtSel     in   1          1 = sign-extend, 0 = zero-extend
//   Out        out  OUT_WIDTH  extended immediate, one cycle after the inputs
// ---------------------------------------------------------------------------
module sign_zero_extend #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [IN_WIDTH-1:0]  Immediate,
    input  logic                 ExtSel,
    output logic [OUT_WIDTH-1:0] Out
);

    logic [OUT_WIDTH-1:0] ext_next;
    logic [OUT_WIDTH-1:0] out_reg;

    // The low bits always pass straight through.
    assign ext_next[IN_WIDTH-1:0] = Immediate;

    // The upper bits exist only when the output is wider than the input.
    // When the widths are equal, ExtSel has nothing to act on. The fill logic
    // is therefore generated only in the widening case, which keeps the
    // equal-width build free of a zero-width slice.
    generate
        if (OUT_WIDTH > IN_WIDTH) begin : g_widen
            logic fill_bit;

            // Zero-extension ignores the MSB. Sign-extension with MSB=0 gives
            // the same result.
            assign fill_bit = ExtSel & Immediate[IN_WIDTH-1];

            for (genvar gi = IN_WIDTH; gi < OUT_WIDTH; gi++) begin : g_fill
                assign ext_next[gi] = fill_bit;
            end
        end else begin : g_same
            logic unused_sel;
            assign unused_sel = ExtSel;
        end
    endgenerate

    // Reset takes priority over the inputs, so Out is a defined 0 even when
    // the inputs are X.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            out_reg <= '0;
        end else begin
            out_reg <= ext_next;
        end
    end

    assign Out = out_reg;

endmodule

// File: tb/tb_sign_zero_extend.sv
// ---------------------------------------------------------------------------
// tb_sign_zero_extend
//   Directed-vector bench for sign_zero_extend (IN_WIDTH=16, OUT_WIDTH=32).
//   The stimulus drives the inputs on the falling edge and pushes the
//   hand-computed expected Out into a queue. The monitor works on each rising
//   edge. If an entry is pending, it pops it, checks Out just after the edge,
//   and checks it again mid-cycle to confirm that Out holds between edges.
// ---------------------------------------------------------------------------
module tb_sign_zero_extend;

    localparam int IW = 16;
    localparam int OW = 32;

    typedef struct {
        logic [OW-1:0] exp;
        string         name;
    } exp_t;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [IW-1:0] Immediate;
    logic          ExtSel;
    logic [OW-1:0] Out;

    exp_t sb_q[$];
    int   tests  = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    sign_zero_extend #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Immediate (Immediate),
        .ExtSel    (ExtSel),
        .Out       (Out)
    );

    always #5 CLK = ~CLK;

    // Issue one transaction. The value in exp is what Out must show after the
    // next rising edge.
    task automatic apply(input logic rst, input logic [IW-1:0] imm,
                         input logic sel, input logic [OW-1:0] exp,
                         input string name);
        exp_t e;
        @(negedge CLK);
        Reset     = rst;
        Immediate = imm;
        ExtSel    = sel;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: one expected value per rising edge while entries are pending.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                #1;
                tests++;
                if (Out !== e.exp) begin
                    errors++;
                    $display("FAIL %s: Out=%h expected %h", e.name, Out, e.exp);
                end else begin
                    $display("[TB] %-14s rst=%b sel=%b imm=%h Out=%h ok",
                             e.name, Reset, ExtSel, Immediate, Out);
                end
                #3;
                tests++;
                if (Out !== e.exp) begin
                    errors++;
                    $display("FAIL %s_hold: Out=%h expected %h (changed between edges)",
                             e.name, Out, e.exp);
                end
            end
        end
    end

    initial begin : stimulus
        Reset     = 1'b1;
        Immediate = '0;
        ExtSel    = 1'b0;

        // Reset for two edges, with arbitrary inputs present.
        apply(1'b1, 16'h1234, 1'b1, 32'h0000_0000, "reset_1");
        apply(1'b1, 16'hFFFF, 1'b1, 32'h0000_0000, "reset_2");

        // Basic zero-extension and sign-extension.
        apply(1'b0, 16'h0007, 1'b0, 32'h0000_0007, "zext_7");
        apply(1'b0, 16'h000A, 1'b1, 32'h0000_000A, "sext_A");
        apply(1'b0, 16'h8007, 1'b1, 32'hFFFF_8007, "sext_8007");
        apply(1'b0, 16'h8007, 1'b0, 32'h0000_8007, "zext_8007");

        // Boundary patterns.
        apply(1'b0, 16'hFFFF, 1'b1, 32'hFFFF_FFFF, "sext_FFFF");
        apply(1'b0, 16'h7FFF, 1'b1, 32'h0000_7FFF, "sext_7FFF");
        apply(1'b0, 16'hFFFF, 1'b0, 32'h0000_FFFF, "zext_FFFF");
        apply(1'b0, 16'h7FFF, 1'b0, 32'h0000_7FFF, "zext_7FFF");
        apply(1'b0, 16'h0000, 1'b1, 32'h0000_0000, "sext_0000");
        apply(1'b0, 16'h8000, 1'b0, 32'h0000_8000, "zext_8000");
        apply(1'b0, 16'h4000, 1'b1, 32'h0000_4000, "sext_4000");

        // Reset mid-stream, then recovery.
        apply(1'b0, 16'h8000, 1'b1, 32'hFFFF_8000, "sext_8000");
        apply(1'b1, 16'h8000, 1'b1, 32'h0000_0000, "reset_mid");
        apply(1'b0, 16'h8000, 1'b1, 32'hFFFF_8000, "post_reset");
        apply(1'b0, 16'h8000, 1'b1, 32'hFFFF_8000, "hold_8000");
        apply(1'b0, 16'h5A5A, 1'b1, 32'h0000_5A5A, "sext_5A5A");
        apply(1'b0, 16'hA5A5, 1'b1, 32'hFFFF_A5A5, "sext_A5A5");

        // Drain the scoreboard within a bounded number of cycles.
        repeat (4) @(posedge CLK);
        #6;
        tests++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", sb_q.size());
        end
        stim_done = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin : watchdog
        #20000;
        if (!stim_done) begin
            $display("FAIL watchdog: timeout expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
